window_gen_stream: RTL and testbench
====================================

Name: window_gen_stream

Overview:
- Parametrised successor to the fixed 3x3 filter front end: builds a WIN x WIN sliding pixel window from a raster stream, using WIN-1 internal line buffers.
- Adds a valid/ready handshake with backpressure, row/column tracking, and a window-valid qualifier that asserts only for windows lying fully inside the image.
- Sits between the pixel input stream and the operation (kernel) unit; the packed window bus layout matches what the operation unit consumes.

Parameters:
- PIX_WIDTH, 8, pixel value bits.
- TAG_WIDTH, 2, tag bits carried above the pixel; passed through untouched.
- WIN, 3, window side; odd, 3..7.
- ADDR_WIDTH, 10, column/row counter width.
- MAX_WIDTH, 1024, line buffer depth; must be <= 2**ADDR_WIDTH.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- reflesh  in  1  synchronous frame restart; same clearing effect as rst.
- image_width  in  ADDR_WIDTH  pixels per line; sampled continuously, changed only while rst or reflesh is high.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block can accept a pixel.
- in_data  in  PIX_WIDTH+TAG_WIDTH  {tag, pixel}.
- win_valid  out  1  win_bus holds a complete in-image window.
- win_ready  in  1  downstream consumes the window.
- win_bus  out  WIN*WIN*(PIX_WIDTH+TAG_WIDTH)  packed window; element (y,x) at [((y*WIN)+x)*DW +: DW], DW=PIX_WIDTH+TAG_WIDTH. y=0 is the oldest row, x=0 the oldest column.

Behaviour:
- Accept condition: in_valid && in_ready. in_ready = !win_valid || win_ready (combinational), so a single output stage is held under backpressure.
- On rst or reflesh:
  - col, row, all window registers and win_valid go to 0; in_ready goes to 1.
  - Line buffer contents are not cleared; their stale data is masked by the row gating below.
- Column tap on accept:
  - t[WIN-1] = in_data.
  - t[WIN-2-k] = lb[k][col] for k = 0..WIN-2 (asynchronous read at the current col).
  - Writes: lb[0][col] <= in_data; lb[k][col] <= lb[k-1][col] for k >= 1.
- Window shift on accept: d[y][x] <= d[y][x+1]; d[y][WIN-1] <= t[y].
- Counters on accept:
  - If col == eff_width-1: col <= 0 and row <= row+1, with row saturating at all-ones.
  - Otherwise col <= col+1.
  - eff_width = MAX_WIDTH when image_width == 0 or image_width > MAX_WIDTH; otherwise eff_width = image_width.
- win_valid:
  - On accept, win_valid <= (col >= WIN-1) && (row >= WIN-1), evaluated on the pre-increment col/row.
  - If there is no accept and win_ready is high, win_valid <= 0.
- Latency: 1 cycle from accepting the bottom-right pixel to win_valid=1 with the full window on win_bus.
- win_bus is stable while win_valid && !win_ready.
- Windows per frame: (eff_width-WIN+1)*(rows-WIN+1). If eff_width < WIN, win_valid never asserts.
- Tags are never interpreted; frame boundaries are marked by reflesh only.
- rst/reflesh mid-stream: the pending window is discarded, and the next accepted pixel is treated as (row 0, col 0).

Optional Feature:
- Macro: WINGEN_POS_EN.
- Defined:
  - Adds outputs win_x and win_y (ADDR_WIDTH each), registered together with win_bus.
  - Values are the window-centre coordinates: col-(WIN-1)/2 and row-(WIN-1)/2, taken pre-increment at the accept cycle.
  - Both reset to 0 and are held under backpressure.
- Undefined: the ports are absent; behaviour is otherwise identical.

Test Plan:
- WIN=3, image_width=4, ramp 0..15 streamed with win_ready=1:
  - First win_valid appears 1 cycle after pixel 10, with bus elements (y0..y2) = 0,1,2 / 4,5,6 / 8,9,10.
  - Exactly 4 windows in total; the last is 5,6,7 / 9,10,11 / 13,14,15.
- Same stream, win_ready=0 for 5 cycles after the first window:
  - in_ready=0 throughout; win_bus is unchanged.
  - After release, the remaining windows arrive in order with none dropped or duplicated.
- image_width=2, 16 pixels -> win_valid never 1, and in_ready stays 1.
- reflesh pulsed after pixel 7, then ramp 0..15 -> output is identical to the first scenario; no stale line-buffer data appears.
- WINGEN_POS_EN defined, first scenario -> win_x/win_y sequence is (1,1), (2,1), (1,2), (2,2).
- WIN=5, image_width=6, 36 pixels -> 4 windows; the first is centred on pixel 14 and contains pixel 0 at element (0,0).

Source files
------------

// File: rtl/window_gen_stream.sv
`timescale 1ns/1ps
// WIN x WIN sliding window generator over a raster pixel stream, with valid/ready handshake.
// Optional macro WINGEN_POS_EN adds win_x/win_y window-centre coordinate outputs.
module window_gen_stream #(
    parameter int PIX_WIDTH  = 8,
    parameter int TAG_WIDTH  = 2,
    parameter int WIN        = 3,
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_WIDTH  = 1024
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       reflesh,
    input  logic [ADDR_WIDTH-1:0]                      image_width,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic [PIX_WIDTH+TAG_WIDTH-1:0]             in_data,
    output logic                                       win_valid,
    input  logic                                       win_ready,
    output logic [WIN*WIN*(PIX_WIDTH+TAG_WIDTH)-1:0]   win_bus
`ifdef WINGEN_POS_EN
    ,
    output logic [ADDR_WIDTH-1:0]                      win_x,
    output logic [ADDR_WIDTH-1:0]                      win_y
`endif
);

    localparam int DW   = PIX_WIDTH + TAG_WIDTH;
    localparam int HALF = (WIN - 1) / 2;
    localparam logic [ADDR_WIDTH:0]   MAXW = (ADDR_WIDTH+1)'(MAX_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] EDGE = ADDR_WIDTH'(WIN - 1);

    logic [ADDR_WIDTH-1:0]             col, row, last_col;
    logic [ADDR_WIDTH:0]               eff_w;
    logic                              accept, clr;
    logic [DW-1:0]                     lb [WIN-1][MAX_WIDTH];
    logic [WIN-1:0][DW-1:0]            tap;
    logic [WIN-1:0][WIN-1:0][DW-1:0]   d;

    assign clr      = rst || reflesh;
    assign in_ready = !win_valid || win_ready;
    assign accept   = in_valid && in_ready;
    assign win_bus  = d;

    // Zero or oversize widths fall back to the full line buffer depth.
    always_comb begin
        eff_w = {1'b0, image_width};
        if (image_width == '0 || {1'b0, image_width} > MAXW)
            eff_w = MAXW;
    end
    assign last_col = ADDR_WIDTH'(eff_w - 1'b1);

    // Column tap: newest pixel at the bottom, line buffers supply older rows.
    assign tap[WIN-1] = in_data;
    for (genvar k = 0; k < WIN - 1; k++) begin : g_tap
        assign tap[WIN-2-k] = lb[k][col];
    end

    // Line buffers are never cleared; stale rows are masked by the row gate.
    always_ff @(posedge clk) begin
        if (accept && !clr) begin
            lb[0][col] <= in_data;
            for (int k = 1; k < WIN - 1; k++)
                lb[k][col] <= lb[k-1][col];
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            col       <= '0;
            row       <= '0;
            d         <= '0;
            win_valid <= 1'b0;
`ifdef WINGEN_POS_EN
            win_x     <= '0;
            win_y     <= '0;
`endif
        end else if (accept) begin
            for (int y = 0; y < WIN; y++)
                d[y] <= {tap[y], d[y][WIN-1:1]};
            win_valid <= (col >= EDGE) && (row >= EDGE);
`ifdef WINGEN_POS_EN
            win_x     <= col - ADDR_WIDTH'(HALF);
            win_y     <= row - ADDR_WIDTH'(HALF);
`endif
            if (col == last_col) begin
                col <= '0;
                if (row != '1)
                    row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end else if (win_ready) begin
            win_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_window_gen_stream.sv
`timescale 1ns/1ps
// Scoreboard bench: stimulus pushes expected windows, negedge monitors pop and compare.
module tb_window_gen_stream;

    localparam int DW = 10;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic refl = 1'b0;
    always #5 clk = ~clk;

    logic [AW-1:0]      w3, w5;
    logic               iv3, ir3, vld3, wr3, iv5, ir5, vld5, wr5;
    logic [DW-1:0]      id3, id5;
    logic [9*DW-1:0]    bus3;
    logic [25*DW-1:0]   bus5;
`ifdef WINGEN_POS_EN
    logic [AW-1:0]      x3, y3, x5, y5;
`endif

    window_gen_stream #(.WIN(3)) dut3 (
        .clk(clk), .rst(rst), .reflesh(refl), .image_width(w3),
        .in_valid(iv3), .in_ready(ir3), .in_data(id3),
        .win_valid(vld3), .win_ready(wr3), .win_bus(bus3)
`ifdef WINGEN_POS_EN
        , .win_x(x3), .win_y(y3)
`endif
    );

    window_gen_stream #(.WIN(5)) dut5 (
        .clk(clk), .rst(rst), .reflesh(refl), .image_width(w5),
        .in_valid(iv5), .in_ready(ir5), .in_data(id5),
        .win_valid(vld5), .win_ready(wr5), .win_bus(bus5)
`ifdef WINGEN_POS_EN
        , .win_x(x5), .win_y(y5)
`endif
    );

    typedef struct {
        logic [249:0]  bus;
        logic [AW-1:0] x;
        logic [AW-1:0] y;
    } exp_t;

    exp_t q3[$], q5[$];
    exp_t e3, e5;
    int n_chk = 0, n_pass = 0, cnt3 = 0, cnt5 = 0, irdy_low3 = 0;
    logic [249:0] first3, last3, first5, saved;

    function automatic logic [DW-1:0] mk(int p);
        return {2'(p + 1), 8'(p)};
    endfunction

    // Geometric model: window whose bottom-right pixel is (r,c) in a ramp image.
    function automatic logic [249:0] exp_win(int w, int n, int r, int c);
        logic [249:0] b;
        b = '0;
        for (int y = 0; y < n; y++)
            for (int x = 0; x < n; x++)
                b[((y*n)+x)*DW +: DW] = mk((r-n+1+y)*w + (c-n+1+x));
        return b;
    endfunction

    function automatic logic [249:0] pix(logic [249:0] b, int n, int y, int x);
        logic [249:0] v;
        v = '0;
        v[7:0] = b[((y*n)+x)*DW +: 8];
        return v;
    endfunction

    task automatic check(string name, logic [249:0] got, logic [249:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    always @(negedge clk) begin
        if (!rst && !refl) begin
            if (!ir3) irdy_low3++;
            if (vld3 && wr3) begin
                if (q3.size() == 0) check("win3_unexpected", 250'd1, 250'd0);
                else begin
                    e3 = q3.pop_front();
                    check("win3_bus", {160'b0, bus3}, e3.bus);
`ifdef WINGEN_POS_EN
                    check("win3_x", {240'b0, x3}, {240'b0, e3.x});
                    check("win3_y", {240'b0, y3}, {240'b0, e3.y});
`endif
                    if (cnt3 == 0) first3 = {160'b0, bus3};
                    last3 = {160'b0, bus3};
                    cnt3++;
                end
            end
            if (vld5 && wr5) begin
                if (q5.size() == 0) check("win5_unexpected", 250'd1, 250'd0);
                else begin
                    e5 = q5.pop_front();
                    check("win5_bus", bus5, e5.bus);
`ifdef WINGEN_POS_EN
                    check("win5_x", {240'b0, x5}, {240'b0, e5.x});
                    check("win5_y", {240'b0, y5}, {240'b0, e5.y});
`endif
                    if (cnt5 == 0) first5 = bus5;
                    cnt5++;
                end
            end
        end
    end

    task automatic send(int sel, int p, int w, int n);
        exp_t e;
        int r, c;
        r = p / w;
        c = p % w;
        if (r >= n-1 && c >= n-1) begin
            e.bus = exp_win(w, n, r, c);
            e.x   = AW'(c - (n-1)/2);
            e.y   = AW'(r - (n-1)/2);
            if (sel == 3) q3.push_back(e); else q5.push_back(e);
        end
        if (sel == 3) begin iv3 = 1'b1; id3 = mk(p); end
        else          begin iv5 = 1'b1; id5 = mk(p); end
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if ((sel == 3) ? ir3 : ir5) begin
                @(posedge clk); #1;
                iv3 = 1'b0; iv5 = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        check("send_timeout", 250'd0, 250'd1);
        iv3 = 1'b0; iv5 = 1'b0;
    endtask

    task automatic stream(int sel, int n_pix, int w, int n);
        for (int p = 0; p < n_pix; p++) send(sel, p, w, n);
    endtask

    task automatic do_reset(int width3);
        rst = 1'b1;
        w3  = AW'(width3);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cnt3 = 0; cnt5 = 0; irdy_low3 = 0;
    endtask

    task automatic drain();
        repeat (4) @(posedge clk);
        #1;
    endtask

    int f1[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    int l1[9] = '{5, 6, 7, 9, 10, 11, 13, 14, 15};

    initial begin
        iv3 = 0; iv5 = 0; id3 = '0; id5 = '0; wr3 = 1; wr5 = 1; w3 = 4; w5 = 6;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_vld3", {249'b0, vld3}, 250'd0);
        check("rst_ready3", {249'b0, ir3}, 250'd1);
        check("rst_bus3", {160'b0, bus3}, 250'd0);
        check("rst_bus5", bus5, 250'd0);
        @(posedge clk); #1;

        // Ramp, free-flowing output
        stream(3, 16, 4, 3);
        drain();
        check("s1_count", 250'(cnt3), 250'd4);
        check("s1_queue", 250'(q3.size()), 250'd0);
        for (int i = 0; i < 9; i++) begin
            check("s1_first", pix(first3, 3, i/3, i%3), 250'(f1[i]));
            check("s1_last", pix(last3, 3, i/3, i%3), 250'(l1[i]));
        end

        // Backpressure right after the first window
        do_reset(4);
        fork
            stream(3, 16, 4, 3);
            begin : stall
                int k;
                k = 0;
                while (k < 200 && !vld3) begin
                    @(posedge clk); #2;
                    k++;
                end
                if (k == 200) check("s2_wait_timeout", 250'd0, 250'd1);
                wr3 = 1'b0;
                saved = {160'b0, bus3};
                check("s2_first_centre", pix(saved, 3, 1, 1), 250'd5);
                repeat (5) begin
                    @(negedge clk);
                    check("s2_in_ready", {249'b0, ir3}, 250'd0);
                    check("s2_hold_bus", {160'b0, bus3}, saved);
                end
                @(posedge clk); #2;
                wr3 = 1'b1;
            end
        join
        drain();
        check("s2_count", 250'(cnt3), 250'd4);
        check("s2_queue", 250'(q3.size()), 250'd0);

        // Image narrower than the window
        do_reset(2);
        stream(3, 16, 2, 3);
        drain();
        check("s3_count", 250'(cnt3), 250'd0);
        check("s3_ready_low", 250'(irdy_low3), 250'd0);

        // Frame restart mid-stream
        do_reset(4);
        stream(3, 8, 4, 3);
        refl = 1'b1;
        @(posedge clk); #1;
        refl = 1'b0;
        @(negedge clk);
        check("s4_bus_cleared", {160'b0, bus3}, 250'd0);
        check("s4_vld_cleared", {249'b0, vld3}, 250'd0);
        @(posedge clk); #1;
        cnt3 = 0;
        stream(3, 16, 4, 3);
        drain();
        check("s4_count", 250'(cnt3), 250'd4);
        for (int i = 0; i < 9; i++)
            check("s4_first", pix(first3, 3, i/3, i%3), 250'(f1[i]));

        // 5x5 window on a 6x6 image
        stream(5, 36, 6, 5);
        drain();
        check("s5_count", 250'(cnt5), 250'd4);
        check("s5_elem00", pix(first5, 5, 0, 0), 250'd0);
        check("s5_centre", pix(first5, 5, 2, 2), 250'd14);
        check("s5_elem44", pix(first5, 5, 4, 4), 250'd28);
        check("s5_queue", 250'(q5.size()), 250'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
